// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the STATUS word packer.
package uart_tx_periph_pkg;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf);
        logic [31:0] w;
        w = '0;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_BUSY]  = busy;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go through a small FIFO and
// are shifted out LSB first at a bit period of DIV+1 clocks.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  regSel,
    input  logic        we,
    input  logic [31:0] di,
    output logic [31:0] do_o,
    output logic        tx,
    output logic        irq
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        unused_di_hi;

    assign unused_di_hi = ^di[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (di[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Register writes and the sticky overflow flag.
    always_comb begin
        fifo_push = we && (regSel == UART_DATA);
        div_d     = div_q;
        ovf_d     = ovf_q;
        if (we && (regSel == UART_DIV)) begin
            div_d = di[15:0];
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
        if (we && (regSel == UART_STATUS) && di[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        irq_d = fifo_empty && (state_q == ST_IDLE);
    end

    // Frame sequencer; DIV is latched at every pop so mid-frame writes wait.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        per_cnt_d = per_cnt_q;
        div_lat_d = div_lat_q;
        fifo_pop  = 1'b0;
        tx        = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    per_cnt_d = div_q;
                    div_lat_d = div_q;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (per_cnt_q == 16'd0) begin
                    per_cnt_d = div_lat_q;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    per_cnt_d = per_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                tx = shift_q[0];
                if (per_cnt_q == 16'd0) begin
                    per_cnt_d = div_lat_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    per_cnt_d = per_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (per_cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        per_cnt_d = div_q;
                        div_lat_d = div_q;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    per_cnt_d = per_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        do_o = 32'd0;
        case (regSel)
            UART_DATA:   do_o = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
            UART_STATUS: do_o = status_word(fifo_full, fifo_empty,
                                            state_q != ST_IDLE, ovf_q);
            UART_DIV:    do_o = {16'd0, div_q};
            default:     do_o = 32'd0;
        endcase
    end

    assign irq = irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            div_q   <= DEFAULT_DIV;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    // Datapath registers are only meaningful once the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_d;
        per_cnt_q <= per_cnt_d;
        div_lat_q <= div_lat_d;
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: frame timing, back-to-back frames,
// overflow handling, DIV latching, mid-frame reset and unmapped offsets.
module tb_uart_tx_periph;

    logic        clk;
    logic        reset;
    logic [3:0]  regSel;
    logic        we;
    logic [31:0] di;
    logic [31:0] do_o;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_tx_periph #(
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .regSel (regSel),
        .we     (we),
        .di     (di),
        .do_o   (do_o),
        .tx     (tx),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level on the line for frame bit i: start, 8 data bits LSB first, stop.
    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        regSel = a;
        di     = d;
        we     = 1'b1;
        @(posedge clk);
        #1;
        we     = 1'b0;
        regSel = 4'h4;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        regSel = a;
        #1;
        v = do_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", irq); end
        rd(4'h4, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 00000002", v); end
        rd(4'h8, v);
        checks++;
        if (v !== 32'd867) begin errors++; $display("FAIL reset_div got %0d want 867", v); end
        rd(4'h0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", v); end
    endtask

    task automatic test_single_frame();
        logic [31:0] v;
        do_reset();
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h55);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_e0 got %b want 1", irq); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_e0 got %b want 1", tx); end
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== fbit(8'h55, k / 4)) begin
                errors++;
                $display("FAIL frame55 cycle %0d got %b want %b", k, tx, fbit(8'h55, k / 4));
            end
            if (k == 0) begin
                checks++;
                if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_e1 got %b want 0", irq); end
            end
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_frame got %b want 1", tx); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_frame got %b want 1", irq); end
        rd(4'h4, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL status_after_frame got %h want 00000002", v); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] bytes;
        logic [7:0]  b;
        logic [31:0] v;
        bytes = 24'hFF3CA5;
        do_reset();
        wr(4'h8, 32'd1);
        wr(4'h0, 32'hA5);
        @(negedge clk);
        regSel = 4'h0; di = 32'h3C; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            b = bytes[(k / 20) * 8 +: 8];
            checks++;
            if (tx !== fbit(b, (k % 20) / 2)) begin
                errors++;
                $display("FAIL b2b cycle %0d got %b want %b", k, tx, fbit(b, (k % 20) / 2));
            end
            if (k == 0) begin
                regSel = 4'h0; di = 32'hFF; we = 1'b1;
            end else begin
                we = 1'b0; regSel = 4'h4;
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx got %b want 1", tx); end
        rd(4'h4, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL b2b_status got %h want 00000002", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        do_reset();
        wr(4'h8, 32'd100);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            regSel = 4'h0; di = 32'h10 + i; we = 1'b1;
        end
        @(negedge clk);
        we = 1'b0;
        rd(4'h4, v);
        checks++;
        if (v !== 32'hD) begin errors++; $display("FAIL ovf_status got %h want 0000000D", v); end
        rd(4'h0, v);
        checks++;
        if (v !== 32'h11) begin errors++; $display("FAIL ovf_head got %h want 00000011", v); end
        wr(4'h4, 32'h8);
        rd(4'h4, v);
        checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL ovf_clear got %h want 00000005", v); end
    endtask

    task automatic test_div_change();
        logic [31:0] v;
        logic        e;
        do_reset();
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h0F);
        @(negedge clk);
        regSel = 4'h0; di = 32'hF0; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; regSel = 4'h4;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            e = (k < 40) ? fbit(8'h0F, k / 4) : fbit(8'hF0, (k - 40) / 8);
            checks++;
            if (tx !== e) begin
                errors++;
                $display("FAIL divchg cycle %0d got %b want %b", k, tx, e);
            end
            if (k == 10) begin
                regSel = 4'h8; di = 32'd7; we = 1'b1;
            end else if (k == 11) begin
                we = 1'b0; regSel = 4'h4;
            end
        end
        rd(4'h8, v);
        checks++;
        if (v !== 32'd7) begin errors++; $display("FAIL divchg_readback got %0d want 7", v); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int          low_seen;
        do_reset();
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h55);
        @(negedge clk);
        regSel = 4'h0; di = 32'h33; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; regSel = 4'h4;
        for (int k = 0; k < 22; k++) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx got %b want 1", tx); end
        regSel = 4'h4;
        #1;
        checks++;
        if (do_o !== 32'h2) begin errors++; $display("FAIL midreset_status got %h want 00000002", do_o); end
        regSel = 4'h8;
        #1;
        checks++;
        if (do_o !== 32'd867) begin errors++; $display("FAIL midreset_div got %0d want 867", do_o); end
        @(negedge clk);
        reset = 1'b1;
        low_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen != 0) begin errors++; $display("FAIL midreset_no_restart got %0d low cycles want 0", low_seen); end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        int          low_seen;
        do_reset();
        rd(4'hC, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL read_0xC got %h want 0", v); end
        rd(4'h1, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL read_0x1 got %h want 0", v); end
        wr(4'hC, 32'hFFFF_FFFF);
        wr(4'h1, 32'hFFFF_FFFF);
        rd(4'h8, v);
        checks++;
        if (v !== 32'd867) begin errors++; $display("FAIL unmapped_div got %0d want 867", v); end
        rd(4'h4, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL unmapped_status got %h want 00000002", v); end
        low_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen != 0) begin errors++; $display("FAIL unmapped_tx got %0d low cycles want 0", low_seen); end
    endtask

    initial begin
        reset  = 1'b0;
        we     = 1'b0;
        regSel = 4'h4;
        di     = 32'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_div_change();
        test_reset_mid_frame();
        test_unmapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
